// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared oscillator types, default widths and constants
package synth_pkg;

  typedef enum logic [1:0] {
    SQUARE = 2'd0,
    PULSE  = 2'd1,
    SAW    = 2'd2,
    TRI    = 2'd3
  } osc_mode_e;

  localparam int DEF_PHASE_W = 24;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_DUTY_W  = 8;

  // Tick reference used when converting a frequency into a phase increment.
  localparam int REF_CLK_HZ  = 1_000_000;

  function automatic int sample_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/osc_shaper.sv
// rtl/osc_shaper.sv - combinational phase-to-sample waveform shaper
module osc_shaper
  import synth_pkg::*;
#(
  parameter int OUT_W  = DEF_OUT_W,
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic [OUT_W-1:0]        u_i,
  input  osc_mode_e               mode_i,
  input  logic [DUTY_W-1:0]       duty_i,
  output logic signed [OUT_W-1:0] sample_o
);

  localparam logic signed [OUT_W-1:0] MAX  = OUT_W'(sample_max(OUT_W));
  localparam logic [OUT_W-1:0]        HALF = {1'b1, {(OUT_W-1){1'b0}}};

  logic [DUTY_W-1:0] d;
  logic [OUT_W-2:0]  t;

  always_comb begin
    d        = u_i[OUT_W-1 -: DUTY_W];
    t        = u_i[OUT_W-1] ? ~u_i[OUT_W-2:0] : u_i[OUT_W-2:0];
    sample_o = '0;
    case (mode_i)
      SQUARE:  sample_o = u_i[OUT_W-1] ? -MAX : MAX;
      PULSE:   sample_o = (d < duty_i) ? MAX : -MAX;
      SAW:     sample_o = {~u_i[OUT_W-1], u_i[OUT_W-2:0]};
      default: sample_o = {t, 1'b0} - HALF;
    endcase
  end

endmodule

// File: rtl/osc_multi.sv
// rtl/osc_multi.sv - phase-accumulator oscillator with wrap-synchronous config apply
module osc_multi
  import synth_pkg::*;
#(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int DUTY_W  = DEF_DUTY_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    sync,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [PHASE_W-1:0]      cfg_inc,
  input  logic [1:0]              cfg_mode,
  input  logic [DUTY_W-1:0]       cfg_duty,
  output logic signed [OUT_W-1:0] sample,
  output logic                    sample_valid,
  output logic                    wrap
);

  logic [PHASE_W-1:0]      phase_q, phase_d, inc_q, inc_d;
  osc_mode_e               mode_q, mode_d;
  logic [DUTY_W-1:0]       duty_q, duty_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [PHASE_W-1:0]      pend_inc_q, pend_inc_d;
  osc_mode_e               pend_mode_q, pend_mode_d;
  logic [DUTY_W-1:0]       pend_duty_q, pend_duty_d;
  logic signed [OUT_W-1:0] sample_q, sample_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    wrap_q, wrap_d;

  logic                    carry;
  logic [PHASE_W-1:0]      sum, phase_n;
  logic                    apply;
  logic signed [OUT_W-1:0] shaped;

  // Shaping uses the active (pre-apply) mode/duty; new values take effect next step.
  osc_shaper #(
    .OUT_W  (OUT_W),
    .DUTY_W (DUTY_W)
  ) u_shaper (
    .u_i      (phase_n[PHASE_W-1 -: OUT_W]),
    .mode_i   (mode_q),
    .duty_i   (duty_q),
    .sample_o (shaped)
  );

  assign cfg_ready    = ~pend_valid_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign wrap         = wrap_q;

  always_comb begin
    {carry, sum} = {1'b0, phase_q} + {1'b0, inc_q};
    phase_n      = sync ? '0 : sum;
    // A stopped oscillator never wraps, so it takes the pending slot immediately.
    apply        = pend_valid_q && (sync || (tick && carry) || (inc_q == '0));

    phase_d        = phase_q;
    inc_d          = inc_q;
    mode_d         = mode_q;
    duty_d         = duty_q;
    pend_valid_d   = pend_valid_q;
    pend_inc_d     = pend_inc_q;
    pend_mode_d    = pend_mode_q;
    pend_duty_d    = pend_duty_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    wrap_d         = 1'b0;

    if (sync || tick) begin
      phase_d        = phase_n;
      sample_d       = shaped;
      sample_valid_d = 1'b1;
      wrap_d         = sync | carry;
    end

    if (apply) begin
      inc_d        = pend_inc_q;
      mode_d       = pend_mode_q;
      duty_d       = pend_duty_q;
      pend_valid_d = 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pend_inc_d   = cfg_inc;
      pend_mode_d  = osc_mode_e'(cfg_mode);
      pend_duty_d  = cfg_duty;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q        <= '0;
      inc_q          <= '0;
      mode_q         <= SQUARE;
      duty_q         <= {1'b1, {(DUTY_W-1){1'b0}}};
      pend_valid_q   <= 1'b0;
      pend_inc_q     <= '0;
      pend_mode_q    <= SQUARE;
      pend_duty_q    <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      inc_q          <= inc_d;
      mode_q         <= mode_d;
      duty_q         <= duty_d;
      pend_valid_q   <= pend_valid_d;
      pend_inc_q     <= pend_inc_d;
      pend_mode_q    <= pend_mode_d;
      pend_duty_q    <= pend_duty_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      wrap_q         <= wrap_d;
    end
  end

endmodule

// File: tb/tb_osc_multi.sv
// tb/tb_osc_multi.sv - directed self-checking bench for osc_multi
module tb_osc_multi;
  import synth_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               tick;
  logic               sync;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [23:0]        cfg_inc;
  logic [1:0]         cfg_mode;
  logic [7:0]         cfg_duty;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               wrap;

  int checks   = 0;
  int failures = 0;
  int pidx     = 0;
  int tcount   = 0;

  // 62.5 kHz at the 1 MHz reference gives 16 ticks per period.
  localparam longint INC_16 = (64'd62500 * (64'd1 << 24)) / REF_CLK_HZ;

  osc_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .sync         (sync),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_inc      (cfg_inc),
    .cfg_mode     (cfg_mode),
    .cfg_duty     (cfg_duty),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s tick=%0d observed=%0d expected=%0d", tag, tcount, $signed(obs), $signed(exp));
    end
  endtask

  // Expected sample for phase index p (units of 1/16 period) with inc = 2^20.
  function automatic int exp_sample(input int m, input int duty, input int p);
    case (m)
      0:       return (p < 8) ? 32767 : -32767;
      1:       return (p * 16 < duty) ? 32767 : -32767;
      2:       return p * 4096 - 32768;
      default: return (p < 8) ? p * 8192 - 32768 : 32766 - (p - 8) * 8192;
    endcase
  endfunction

  task automatic do_tick(input int m, input int duty);
    tick = 1'b1;
    step();
    pidx = (pidx + 1) % 16;
    tcount++;
    check("wrap", {31'd0, wrap}, (pidx == 0) ? 32'd1 : 32'd0);
    check("sample", sample, exp_sample(m, duty, pidx));
    check("sample_valid", {31'd0, sample_valid}, 32'd1);
  endtask

  task automatic run_to_wrap(input int m, input int duty);
    do do_tick(m, duty); while (pidx != 0);
  endtask

  task automatic offer(input logic [23:0] inc, input logic [1:0] mode, input logic [7:0] duty);
    cfg_inc   = inc;
    cfg_mode  = mode;
    cfg_duty  = duty;
    cfg_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_inc = '0; cfg_mode = '0; cfg_duty = '0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_sample", sample, 32'd0);
    check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // Stopped oscillator: config applies on the next edge without a tick.
    offer(24'(INC_16), 2'd0, 8'd128);
    step();
    cfg_valid = 1'b0;
    check("stop_ready_low", {31'd0, cfg_ready}, 32'd0);
    check("stop_no_valid", {31'd0, sample_valid}, 32'd0);
    step();
    check("stop_ready_high", {31'd0, cfg_ready}, 32'd1);

    for (int i = 0; i < 32; i++) do_tick(0, 128);

    // Saw queued mid-period; square continues through the wrap edge.
    offer(24'(INC_16), 2'd2, 8'd128);
    do_tick(0, 128);
    cfg_valid = 1'b0;
    check("saw_ready_low", {31'd0, cfg_ready}, 32'd0);
    run_to_wrap(0, 128);
    check("saw_ready_high", {31'd0, cfg_ready}, 32'd1);
    run_to_wrap(2, 128);

    offer(24'(INC_16), 2'd1, 8'd64);
    do_tick(2, 128);
    cfg_valid = 1'b0;
    run_to_wrap(2, 128);
    run_to_wrap(1, 64);
    for (int i = 0; i < 4; i++) do_tick(1, 64);
    offer(24'(INC_16), 2'd1, 8'd192);
    do_tick(1, 64);
    cfg_valid = 1'b0;
    check("duty_ready_low", {31'd0, cfg_ready}, 32'd0);
    for (int i = 0; i < 10; i++) do_tick(1, 64);
    check("duty_ready_still_low", {31'd0, cfg_ready}, 32'd0);
    run_to_wrap(1, 64);
    check("duty_ready_high", {31'd0, cfg_ready}, 32'd1);
    run_to_wrap(1, 192);

    offer(24'(INC_16), 2'd3, 8'd128);
    do_tick(1, 192);
    cfg_valid = 1'b0;
    run_to_wrap(1, 192);
    run_to_wrap(3, 128);

    // Hard sync from phase 0x7FF000 with a config pending.
    offer(24'h7FF000, 2'd0, 8'd128);
    do_tick(3, 128);
    cfg_valid = 1'b0;
    run_to_wrap(3, 128);
    tick = 1'b1;
    step();
    check("pre_sync_sample", sample, 32'd32767);
    check("pre_sync_wrap", {31'd0, wrap}, 32'd0);
    tick = 1'b0;
    offer(24'h400000, 2'd2, 8'd128);
    step();
    cfg_valid = 1'b0;
    check("hold_valid", {31'd0, sample_valid}, 32'd0);
    check("hold_sample", sample, 32'd32767);
    check("hold_ready", {31'd0, cfg_ready}, 32'd0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_wrap", {31'd0, wrap}, 32'd1);
    check("sync_sample", sample, 32'd32767);
    check("sync_valid", {31'd0, sample_valid}, 32'd1);
    check("sync_ready", {31'd0, cfg_ready}, 32'd1);
    tick = 1'b1;
    step();
    check("post_sync_saw0", sample, -32'sd16384);
    check("post_sync_wrap", {31'd0, wrap}, 32'd0);
    step();
    check("post_sync_saw1", sample, 32'd0);

    // Reset mid-period discards a pending config.
    tick = 1'b0;
    offer(24'(INC_16), 2'd2, 8'd128);
    step();
    cfg_valid = 1'b0;
    check("pre_rst_ready", {31'd0, cfg_ready}, 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_sample", sample, 32'd0);
    check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("mid_rst_wrap", {31'd0, wrap}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tcount++;
      check("rst_no_wrap", {31'd0, wrap}, 32'd0);
      check("rst_phase0_sample", sample, 32'd32767);
    end
    check("rst_ticks_valid", {31'd0, sample_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
